// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding instruction-memory read, and
// instruction register. Optional misaligned-fetch check enabled by FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_fetch,
    input  logic                  enable_pc,
    input  logic [1:0]            pc_select,
    input  logic [13:0]           imm_14bit,
    input  logic [23:0]           imm_24bit,
    output logic                  im_req,
    output logic [ADDR_WIDTH-1:0] im_addr,
    input  logic [31:0]           im_rdata,
    input  logic                  im_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_busy,
    output logic                  fetch_done,
    output logic                  fetch_fault
);

    // Offsets are formed at least 25 bits wide so a shifted 24-bit displacement never loses sign.
    localparam int unsigned OffW = (ADDR_WIDTH > 25) ? ADDR_WIDTH : 25;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic                  misaligned;

    logic [OffW-1:0]       pc_ext;
    logic [OffW-1:0]       pc_off;
    logic [OffW-1:0]       pc_sum;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-PC datapath
    always_comb begin
        pc_off = '0;
        unique case (pc_select)
            2'b00:   pc_off = OffW'(4);
            2'b01:   pc_off = OffW'($signed({imm_14bit, 1'b0}));
            2'b10:   pc_off = OffW'($signed({imm_24bit, 1'b0}));
            default: pc_off = '0;
        endcase
    end

    assign pc_ext = OffW'(pc_q);
    assign pc_sum = pc_ext + pc_off;

    always_comb begin
        pc_d = pc_q;
        if (enable_pc) begin
            pc_d = pc_sum[ADDR_WIDTH-1:0];
        end
    end

    // Fetch FSM
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        done_d  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable_fetch) begin
                    if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        fault_d = 1'b1;
`endif
                    end else begin
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (im_ready) begin
                    instr_d = im_rdata;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign im_req      = req_q;
    assign im_addr     = addr_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_busy  = req_q;
    assign fetch_done  = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/PC traffic
// against a behavioural model of the PC arithmetic and the fetch handshake.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_fetch;
    logic        enable_pc;
    logic [1:0]  pc_select;
    logic [13:0] imm_14bit;
    logic [23:0] imm_24bit;
    logic        im_req;
    logic [15:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ready;
    logic [31:0] instruction;
    logic [15:0] pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_fault;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mpc;
    logic [31:0] minstr;
    logic        mfault;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .enable_fetch(enable_fetch),
        .enable_pc   (enable_pc),
        .pc_select   (pc_select),
        .imm_14bit   (imm_14bit),
        .imm_24bit   (imm_24bit),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_ready    (im_ready),
        .instruction (instruction),
        .pc          (pc),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] model_next(input logic [15:0] p, input logic [1:0] s,
                                               input logic [13:0] a, input logic [23:0] b);
        int          off;
        logic [31:0] r;
        case (s)
            2'd0:    off = 4;
            2'd1:    off = (int'(a) - (a[13] ? 16384 : 0)) * 2;
            2'd2:    off = (int'(b) - (b[23] ? (1 << 24) : 0)) * 2;
            default: off = 0;
        endcase
        r = int'(p) + off;
        return r[15:0];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        mpc    = 16'h0000;
        minstr = 32'h0;
        mfault = 1'b0;
        step();
    endtask

    task automatic set_pc(input logic [15:0] target);
        logic [15:0] delta;
        delta     = target - mpc;
        enable_pc = 1'b1;
        pc_select = 2'b10;
        imm_24bit = {9'b0, delta[15:1]};
        step();
        enable_pc = 1'b0;
        mpc = model_next(mpc, 2'b10, imm_14bit, imm_24bit);
        n_cmp++;
        if (pc !== target) begin
            n_bad++;
            $display("FAIL set_pc: pc=%h expected %h", pc, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++;
        if ({pc, instruction, im_req, im_addr, fetch_busy, fetch_done, fetch_fault} !==
            {16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: pc=%h instr=%h req=%b addr=%h busy=%b done=%b flt=%b",
                     pc, instruction, im_req, im_addr, fetch_busy, fetch_done, fetch_fault);
        end
        apply_reset();
        n_cmp++;
        if (pc !== 16'h0 || im_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: pc=%h req=%b expected 0000/0", pc, im_req);
        end
    endtask

    task automatic test_fetch_basic();
        im_ready     = 1'b1;
        im_rdata     = 32'h4600_0005;
        enable_fetch = 1'b1;
        step();
        enable_fetch = 1'b0;
        n_cmp++;
        if (im_req !== 1'b1 || im_addr !== 16'h0000 || fetch_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b expected 1/0000/1",
                     im_req, im_addr, fetch_busy);
        end
        step();
        n_cmp++;
        if (instruction !== 32'h4600_0005 || fetch_done !== 1'b1 || im_req !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_resp: instr=%h done=%b req=%b expected 46000005/1/0",
                     instruction, fetch_done, im_req);
        end
        step();
        n_cmp++;
        if (fetch_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done_pulse: done=%b expected 0", fetch_done);
        end
        im_ready = 1'b0;
        minstr   = 32'h4600_0005;
    endtask

    task automatic test_pc_update();
        set_pc(16'h0100);
        enable_pc = 1'b1; pc_select = 2'b01; imm_14bit = 14'h3FFE;
        step();
        enable_pc = 1'b0;
        n_cmp++;
        if (pc !== 16'h00FC) begin
            n_bad++;
            $display("FAIL branch_back: pc=%h expected 00fc", pc);
        end
        mpc = 16'h00FC;
        set_pc(16'h0100);
        enable_pc = 1'b1; pc_select = 2'b10; imm_24bit = 24'h000010;
        step();
        n_cmp++;
        if (pc !== 16'h0120) begin
            n_bad++;
            $display("FAIL jump_fwd: pc=%h expected 0120", pc);
        end
        pc_select = 2'b11;
        step();
        enable_pc = 1'b0;
        n_cmp++;
        if (pc !== 16'h0120) begin
            n_bad++;
            $display("FAIL hold: pc=%h expected 0120", pc);
        end
        mpc = 16'h0120;
        // Randomized single updates, including far jumps that wrap
        for (int i = 0; i < 20; i++) begin
            pc_select = 2'($urandom_range(0, 3));
            imm_14bit = 14'($urandom);
            imm_24bit = 24'($urandom);
            enable_pc = 1'b1;
            step();
            enable_pc = 1'b0;
            mpc = model_next(mpc, pc_select, imm_14bit, imm_24bit);
            n_cmp++;
            if (pc !== mpc) begin
                n_bad++;
                $display("FAIL rand_pc[%0d]: sel=%b pc=%h expected %h", i, pc_select, pc, mpc);
            end
        end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFC);
        enable_pc = 1'b1; pc_select = 2'b00;
        step();
        enable_pc = 1'b0;
        mpc = 16'h0000;
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap: pc=%h expected 0000", pc);
        end
    endtask

    task automatic test_wait_stall();
        int          dones;
        logic [31:0] word;
        set_pc(16'h0240);
        im_ready = 1'b0;
        enable_fetch = 1'b1;
        step();
        enable_fetch = 1'b0;
        dones = 0;
        n_cmp++;
        if (im_req !== 1'b1 || im_addr !== 16'h0240) begin
            n_bad++;
            $display("FAIL stall_req: req=%b addr=%h expected 1/0240", im_req, im_addr);
        end
        enable_fetch = 1'b1; enable_pc = 1'b1; pc_select = 2'b00;
        step();
        enable_fetch = 1'b0; enable_pc = 1'b0;
        mpc = 16'h0244;
        step();
        dones += int'(fetch_done);
        n_cmp++;
        if (im_req !== 1'b1 || im_addr !== 16'h0240 || pc !== 16'h0244) begin
            n_bad++;
            $display("FAIL stall_hold: req=%b addr=%h pc=%h expected 1/0240/0244",
                     im_req, im_addr, pc);
        end
        word = $urandom;
        im_ready = 1'b1; im_rdata = word;
        step();
        im_ready = 1'b0;
        dones += int'(fetch_done);
        n_cmp++;
        if (instruction !== word || fetch_done !== 1'b1 || im_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_resp: instr=%h done=%b req=%b expected %h/1/0",
                     instruction, fetch_done, im_req, word);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            dones += int'(fetch_done);
        end
        minstr = word;
        n_cmp++;
        if (dones != 1 || im_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_single: dones=%0d req=%b expected 1/0", dones, im_req);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        im_ready = 1'b0;
        enable_fetch = 1'b1;
        step();
        enable_fetch = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (im_req !== 1'b0 || fetch_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: req=%b busy=%b expected 0/0", im_req, fetch_busy);
        end
        apply_reset();
        im_ready = 1'b1; im_rdata = 32'hDEAD_BEEF;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            dones += int'(fetch_done);
        end
        im_ready = 1'b0;
        n_cmp++;
        if (im_req !== 1'b0 || instruction !== 32'h0 || dones != 0) begin
            n_bad++;
            $display("FAIL reset_mid: req=%b instr=%h dones=%0d expected 0/00000000/0",
                     im_req, instruction, dones);
        end
    endtask

    task automatic test_align();
        set_pc(16'h0102);
        im_ready = 1'b1; im_rdata = 32'h1234_5678;
        enable_fetch = 1'b1;
        step();
        enable_fetch = 1'b0;
        if (AlignEn) begin
            n_cmp++;
            if (im_req !== 1'b0 || fetch_fault !== 1'b1) begin
                n_bad++;
                $display("FAIL align_fault: req=%b fault=%b expected 0/1", im_req, fetch_fault);
            end
            step(); step();
            n_cmp++;
            if (fetch_fault !== 1'b1 || fetch_done !== 1'b0 || instruction !== minstr) begin
                n_bad++;
                $display("FAIL align_sticky: fault=%b done=%b instr=%h expected 1/0/%h",
                         fetch_fault, fetch_done, instruction, minstr);
            end
            im_ready = 1'b0;
            apply_reset();
            n_cmp++;
            if (fetch_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL align_clear: fault=%b expected 0", fetch_fault);
            end
        end else begin
            n_cmp++;
            if (im_req !== 1'b1 || im_addr !== 16'h0102 || fetch_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL align_off: req=%b addr=%h fault=%b expected 1/0102/0",
                         im_req, im_addr, fetch_fault);
            end
            step();
            im_ready = 1'b0;
            minstr = 32'h1234_5678;
            n_cmp++;
            if (instruction !== 32'h1234_5678 || fetch_done !== 1'b1) begin
                n_bad++;
                $display("FAIL align_off_resp: instr=%h done=%b expected 12345678/1",
                         instruction, fetch_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_addr;
        logic [31:0] word;
        bit          same;
        int          waits;
        for (int t = 0; t < 40; t++) begin
            pc_select = 2'($urandom_range(0, 3));
            imm_14bit = 14'($urandom);
            imm_24bit = 24'($urandom);
            same      = 1'($urandom);
            exp_addr  = mpc;
            im_ready  = 1'b0;
            enable_fetch = 1'b1;
            enable_pc    = same;
            step();
            enable_fetch = 1'b0;
            enable_pc    = 1'b0;
            if (same) mpc = model_next(mpc, pc_select, imm_14bit, imm_24bit);
            if (AlignEn && exp_addr[1:0] != 2'b00) begin
                mfault = 1'b1;
                n_cmp++;
                if (im_req !== 1'b0 || fetch_fault !== 1'b1 || pc !== mpc) begin
                    n_bad++;
                    $display("FAIL rnd_fault[%0d]: req=%b fault=%b pc=%h expected 0/1/%h",
                             t, im_req, fetch_fault, pc, mpc);
                end
                continue;
            end
            n_cmp++;
            if (im_req !== 1'b1 || im_addr !== exp_addr || pc !== mpc) begin
                n_bad++;
                $display("FAIL rnd_req[%0d]: req=%b addr=%h pc=%h expected 1/%h/%h",
                         t, im_req, im_addr, pc, exp_addr, mpc);
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                pc_select = 2'($urandom_range(0, 3));
                enable_pc = 1'($urandom);
                step();
                if (enable_pc) mpc = model_next(mpc, pc_select, imm_14bit, imm_24bit);
                enable_pc = 1'b0;
            end
            word = $urandom;
            im_ready = 1'b1; im_rdata = word;
            step();
            im_ready = 1'b0;
            minstr = word;
            n_cmp++;
            if (instruction !== minstr || fetch_done !== 1'b1 || im_req !== 1'b0 ||
                pc !== mpc || fetch_fault !== mfault) begin
                n_bad++;
                $display("FAIL rnd_resp[%0d]: instr=%h done=%b req=%b pc=%h flt=%b exp %h/1/0/%h/%b",
                         t, instruction, fetch_done, im_req, pc, fetch_fault, minstr, mpc, mfault);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable_fetch = 1'b0; enable_pc = 1'b0; pc_select = 2'b00;
        imm_14bit = '0; imm_24bit = '0; im_rdata = '0; im_ready = 1'b0;
        mpc = 16'h0; minstr = 32'h0; mfault = 1'b0;
        test_reset();
        test_fetch_basic();
        test_pc_update();
        test_wrap();
        test_wait_stall();
        test_reset_mid();
        test_align();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle core. Holds the program counter, issues one instruction-memory read per fetch strobe from the control FSM, and latches the returned word into the instruction register that drives decode. On the PC-update strobe it computes the next PC: sequential, taken branch, or jump, as selected by the control FSM.

## Interface
- ADDR_WIDTH, 16, byte-address width of PC and instruction-memory address
- RESET_PC, 0, PC value after reset (ADDR_WIDTH bits)
- clock  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- enable_fetch  input  1  fetch strobe; single-cycle pulse from control FSM
- enable_pc  input  1  PC-update strobe; single-cycle pulse from control FSM
- pc_select  input  2  00 sequential, 01 branch, 10 jump, 11 hold
- imm_14bit  input  14  branch displacement, halfword units, signed
- imm_24bit  input  24  jump displacement, halfword units, signed
- im_req  output  1  instruction-memory read request, registered
- im_addr  output  ADDR_WIDTH  read address, registered, stable while im_req=1
- im_rdata  input  32  read data, valid when im_ready=1
- im_ready  input  1  read complete; sampled only while im_req=1
- instruction  output  32  instruction register
- pc  output  ADDR_WIDTH  current program counter
- fetch_busy  output  1  high while a request is outstanding (state WAIT)
- fetch_done  output  1  one-cycle pulse, instruction register just updated
- fetch_fault  output  1  sticky misaligned-fetch flag (see Configuration)

## Operation
- States: IDLE, WAIT. Reset -> IDLE.
- IDLE, enable_fetch=1: im_addr<=pc, im_req<=1, -> WAIT.
- WAIT, im_ready=0: hold im_req, im_addr; enable_fetch ignored (no queueing).
- WAIT, im_ready=1: instruction<=im_rdata, fetch_done<=1 for one cycle, im_req<=0, -> IDLE.
- PC update on enable_pc=1, independent of state:
  - 00: pc<=pc+4
  - 01: pc<=pc+(sext(imm_14bit)<<1)
  - 10: pc<=pc+(sext(imm_24bit)<<1)
  - 11: pc unchanged
- Arithmetic truncated to ADDR_WIDTH; wraps modulo 2^ADDR_WIDTH (e.g. 0xFFFC+4 -> 0x0000 at ADDR_WIDTH=16).
- enable_pc during WAIT: pc updates; the outstanding request keeps its registered im_addr.
- enable_fetch and enable_pc in the same IDLE cycle: request uses pre-update pc; pc updates.
- Reset mid-request: im_req drops immediately (asynchronous); a later im_ready is ignored; instruction stays 0.
- Reset values: pc=RESET_PC, instruction=32'h0, im_req=0, im_addr=0, fetch_busy=0, fetch_done=0, fetch_fault=0.

## Timing
- Strobe at cycle N -> im_req=1 visible in N+1.
- im_ready=1 at cycle M (M>=N+1) -> instruction and fetch_done valid in M+1, im_req=0 in M+1.
- Zero-wait memory (im_ready high in N+1): instruction valid at N+2; 2-cycle minimum latency.
- pc visible one cycle after the enable_pc edge.
- fetch_busy equals im_req.
- im_rdata must be valid in the same cycle as im_ready.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: enable_fetch in IDLE with pc[1:0]!=0 issues no request, stays IDLE, leaves instruction unchanged, no fetch_done; fetch_fault<=1 and holds until reset.
- Undefined: no check; im_addr=pc unmodified; fetch_fault tied 0.

## Test plan
- Reset, then enable_fetch, im_ready tied 1, im_rdata=32'h4600_0005 -> im_req/im_addr=0x0000 in N+1; instruction=32'h4600_0005 and fetch_done pulse in N+2.
- pc=0x0100; enable_pc with pc_select=01, imm_14bit=14'h3FFE -> pc=0x00FC; with 10, imm_24bit=24'h000010 -> 0x0120; with 11 -> unchanged.
- pc=0xFFFC, pc_select=00, enable_pc -> pc=0x0000.
- im_ready held low 3 cycles, enable_fetch re-pulsed and enable_pc pulsed mid-WAIT -> single request, im_addr unchanged, pc updated, one fetch_done after im_ready.
- Reset during WAIT, then im_ready=1 with 32'hDEAD_BEEF -> im_req=0, instruction stays 32'h0, no fetch_done.
- FETCH_ALIGN_CHECK_EN: pc=0x0102, enable_fetch -> no im_req, fetch_fault=1 until reset; without macro, im_addr=0x0102 and fetch_fault=0.
